poly_eval_seq: RTL and testbench
================================

# poly_eval_seq

Sequential polynomial evaluator computing y = c_DEG·x^DEG + … + c_1·x + c_0 by Horner's rule, one multiply-accumulate per clock. It is the parametrised successor of the fixed second-degree control/datapath pair: degree and word width are parameters, it uses a start/done handshake with a busy flag, and it reports a sticky overflow flag. It sits between operand-producing logic and any consumer that waits on `done`.

## Interface
- `W`, 16: word width of coefficients, x and result (W ≥ 2).
- `DEG`, 2: polynomial degree (DEG ≥ 0). Coefficient count is DEG+1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. All state is cleared while `rst` = 0.
- `start`  in  1  request. Sampled only in IDLE.
- `x`  in  W  evaluation point, unsigned.
- `coef`  in  (DEG+1)·W  packed coefficients, `coef[W*i +: W]` = c_i, with c_0 the constant term. All unsigned.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  registered single-cycle pulse when the result updates.
- `result`  out  W  last completed value, modulo 2^W. Held until the next completion.
- `ovf`  out  1  overflow flag of the last completed evaluation. Held with `result`.

## Operation
- Internal registers:
  - `xr` (W) and `cr` (DEG+1 words): operand snapshot.
  - `acc` (W): accumulator.
  - `cnt` (enough bits for 0..DEG): step counter.
  - `ovf_acc` (1): sticky overflow.
  - `state` ∈ {IDLE, STEP, FINISH}.
- IDLE:
  - On an edge with `start` = 1: capture `xr` ← x, `cr` ← coef, `acc` ← c_DEG, `cnt` ← DEG, `ovf_acc` ← 0.
  - Next state is STEP if DEG > 0, otherwise FINISH.
  - `start` = 0: remain in IDLE.
- STEP, one edge per coefficient:
  - full = acc·xr + cr[cnt−1], computed at 2W+1 bits.
  - `acc` ← full[W−1:0].
  - `ovf_acc` ← ovf_acc | (full[2W:W] ≠ 0).
  - `cnt` ← cnt−1.
  - When cnt = 1 before the edge, next state is FINISH.
- FINISH, one edge: `result` ← acc, `ovf` ← ovf_acc, `done` ← 1, state ← IDLE.
- `done` is 0 on every edge that is not a FINISH edge.
- `start` is ignored while `busy` = 1; there is no queuing.
- `x` and `coef` may change freely after the capture edge; the evaluation uses the snapshot.
- Arithmetic is unsigned only. Results wrap modulo 2^W, and overflow is reported via `ovf` only.

## Timing
- Reset (`rst` = 0, asynchronous): state = IDLE; `busy`, `done`, `ovf`, `result`, `acc`, `cnt`, `ovf_acc` = 0. Applies immediately regardless of clock.
- Reset mid-operation: the evaluation is abandoned with no `done`, and `result` reads 0. The first `start` after `rst` returns to 1 is accepted normally.
- Latency: `start` sampled at edge E → `busy` high from E to E+DEG+1 → `done` high for exactly one cycle after edge E+DEG+1, with `result` and `ovf` valid from that same edge.
- DEG = 0: `done` follows at E+1, with `result` = c_0 and `ovf` = 0.
- Back-to-back operation: `done` and IDLE coincide. `start` held high is accepted at E+DEG+2, giving one evaluation every DEG+2 cycles.
- `done` never stays high for two consecutive cycles.
- `busy` falls on the same edge on which `done` rises.
- `result` and `ovf` change only at FINISH edges and at reset.

## Test plan
- Basic case: DEG=2, W=16, coef={c2=3, c1=2, c0=0}, x=1, `start` pulsed at E → `busy` high from E to E+3, `done` high exactly one cycle after E+3, `result`=5, `ovf`=0. Changing x and coef at E+1 does not alter the result.
- General value: DEG=2, coef={2,3,4}, x=10 → `result`=234, `ovf`=0, `done` after E+3.
- Overflow: DEG=2, W=16, coef={1,0,0}, x=300 → `result`=24464 (90000 mod 65536), `ovf`=1. A following run with x=2 → `result`=4, `ovf`=0, showing the sticky flag clears per evaluation.
- Handshake with DEG=2:
  - `start` held high continuously → `done` pulses after edges E+3, E+7, E+11.
  - An extra `start` pulse at E+1 changes nothing.
- Reset mid-operation: `rst`=0 between E+1 and E+2 (asynchronous, mid-cycle) → `busy`, `done`, `result`, `ovf` go 0 immediately, with no `done` pulse. After release, a new `start` with coef={3,2,0}, x=1 yields 5 on schedule.
- DEG=0 instance, W=8: coef={c0=200}, x=7 → `done` after E+1, `result`=200, `ovf`=0.

Source files
------------

// File: rtl/poly_eval_if.sv
// rtl/poly_eval_if.sv - start/done handshake bundle for the Horner polynomial evaluator
//
// Ports (signals of the bundle):
//   start   requester -> evaluator   request, sampled only while the evaluator is idle
//   x       requester -> evaluator   W-bit unsigned evaluation point
//   coef    requester -> evaluator   (DEG+1)*W packed unsigned coefficients, coef[W*i +: W] = c_i
//   busy    evaluator -> requester   high while an evaluation is in flight
//   done    evaluator -> requester   single-cycle pulse when result/ovf update
//   result  evaluator -> requester   W-bit last completed value (mod 2^W)
//   ovf     evaluator -> requester   overflow flag of the last completed evaluation
interface poly_eval_if #(
  parameter int W   = 16,
  parameter int DEG = 2
);

  logic                   start;
  logic [W-1:0]           x;
  logic [(DEG+1)*W-1:0]   coef;
  logic                   busy;
  logic                   done;
  logic [W-1:0]           result;
  logic                   ovf;

  modport master (
    output start, x, coef,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, x, coef,
    output busy, done, result, ovf
  );

endinterface

// File: rtl/poly_eval_seq.sv
// rtl/poly_eval_seq.sv - sequential Horner polynomial evaluator, one multiply-accumulate per clock
//
// Computes y = c_DEG*x^DEG + ... + c_1*x + c_0 (unsigned, wrapping mod 2^W) with a
// sticky overflow flag that is set whenever any Horner step exceeds W bits.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset, clears all state
//   bus   poly_eval_if slave: start/x/coef in, busy/done/result/ovf out
module poly_eval_seq #(
  parameter int W   = 16,
  parameter int DEG = 2
) (
  input  logic       clk,
  input  logic       rst,
  poly_eval_if.slave bus
);

  // Counter must hold 0..DEG; keep at least one bit so DEG = 0 still elaborates.
  localparam int CW = (DEG > 0) ? $clog2(DEG + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;

  logic [W-1:0]      xr;
  logic [W-1:0]      cr [0:DEG];
  logic [W-1:0]      acc;
  logic [CW-1:0]     cnt;
  logic              ovf_acc;

  logic [W-1:0]      result_q;
  logic              ovf_q;
  logic              done_q;

  logic              do_load;
  logic              do_step;
  logic              do_finish;

  logic [CW-1:0]     idx;
  logic [W-1:0]      cur_c;
  logic [2*W:0]      full;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // Next state and datapath controls
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          do_load = 1'b1;
          // With no coefficients below c_DEG there is nothing to multiply in.
          state_d = (DEG > 0) ? STEP : FINISH;
        end
      end
      STEP: begin
        do_step = 1'b1;
        if (cnt == CW'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        do_finish = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Horner step: acc*x + c[cnt-1] at full 2W+1 precision
  // ------------------------------------------------------------------
  always_comb begin
    idx   = cnt - CW'(1);
    cur_c = '0;
    // Explicit select keeps the lookup in range for every legal DEG,
    // including counter codes that never occur during STEP.
    for (int i = 0; i <= DEG; i++) begin
      if (idx == CW'(i)) begin
        cur_c = cr[i];
      end
    end
    full = (2*W+1)'(acc) * (2*W+1)'(xr) + (2*W+1)'(cur_c);
  end

  // ------------------------------------------------------------------
  // Datapath and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xr       <= '0;
      for (int i = 0; i <= DEG; i++) begin
        cr[i] <= '0;
      end
      acc      <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= do_finish;

      if (do_load) begin
        // Snapshot operands so the requester may change them immediately.
        xr <= bus.x;
        for (int i = 0; i <= DEG; i++) begin
          cr[i] <= bus.coef[W*i +: W];
        end
        acc     <= bus.coef[W*DEG +: W];
        cnt     <= CW'(DEG);
        ovf_acc <= 1'b0;
      end

      if (do_step) begin
        acc     <= full[W-1:0];
        ovf_acc <= ovf_acc | (|full[2*W:W]);
        cnt     <= cnt - CW'(1);
      end

      if (do_finish) begin
        result_q <= acc;
        ovf_q    <= ovf_acc;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_poly_eval_seq.sv
// tb/tb_poly_eval_seq.sv - randomized self-checking bench for poly_eval_seq (DEG=2/W=16 and DEG=0/W=8)
module tb_poly_eval_seq;

  localparam int W   = 16;
  localparam int DEG = 2;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  poly_eval_if #(.W(W), .DEG(DEG)) b ();
  poly_eval_if #(.W(8), .DEG(0))   b0 ();

  poly_eval_seq #(.W(W), .DEG(DEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  poly_eval_seq #(.W(8), .DEG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value as a plain sum of c_i * x^i mod 2^W; overflow as
  // "some Horner partial result needed more than W bits".
  function automatic void model(input logic [3*W-1:0] c, input logic [W-1:0] xv,
                                output logic [W-1:0] r, output bit o);
    longint unsigned m, sum, p, a, f;
    m   = 64'd1 << W;
    sum = 0;
    p   = 1;
    for (int i = 0; i <= DEG; i++) begin
      sum = (sum + longint'(c[W*i +: W]) * p) % m;
      p   = (p * longint'(xv)) % m;
    end
    r = W'(sum);
    o = 1'b0;
    a = longint'(c[W*DEG +: W]);
    for (int i = DEG - 1; i >= 0; i--) begin
      f = a * longint'(xv) + longint'(c[W*i +: W]);
      if (f >= m) o = 1'b1;
      a = f % m;
    end
  endfunction

  function automatic logic [3*W-1:0] pack3(input int c2, input int c1, input int c0);
    return {W'(c2), W'(c1), W'(c0)};
  endfunction

  // Pulses start for one edge (E) and waits for done. lat = cycles after E
  // at which done was seen (-1 on timeout). busy_ok = busy high through
  // E..E+lat-1 and low with done.
  task automatic do_eval(input logic [3*W-1:0] c, input logic [W-1:0] xv, input bit perturb,
                         output int lat, output bit busy_ok);
    b.coef  = c;
    b.x     = xv;
    b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    lat     = -1;
    busy_ok = b.busy;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (perturb && k == 1) begin
        b.x    = W'($urandom());
        b.coef = {W'($urandom()), 32'($urandom())};
      end
      if (b.done) begin
        lat = k;
        busy_ok = busy_ok & !b.busy;
        break;
      end
      busy_ok = busy_ok & b.busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b.start = 1'b0; b.x = '0; b.coef = '0;
    b0.start = 1'b0; b0.x = '0; b0.coef = '0;
    #2;
    n_checks++;
    if ({b.busy, b.done, b.ovf, b.result} !== {3'b000, 16'h0})
      $display("FAIL reset_outputs: busy=%b done=%b ovf=%b result=%0d expected all 0",
               b.busy, b.done, b.ovf, b.result);
    else n_pass++;
    n_checks++;
    if ({b0.busy, b0.done, b0.ovf, b0.result} !== {3'b000, 8'h0})
      $display("FAIL reset_outputs_deg0: busy=%b done=%b ovf=%b result=%0d expected all 0",
               b0.busy, b0.done, b0.ovf, b0.result);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({b.busy, b.done} !== 2'b00)
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", b.busy, b.done);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat; bit bok;
    do_eval(pack3(3, 2, 0), 16'd1, 1'b1, lat, bok);
    n_checks++;
    if (lat !== DEG + 1) $display("FAIL basic_latency: got %0d expected %0d", lat, DEG + 1);
    else n_pass++;
    n_checks++;
    if (bok !== 1'b1) $display("FAIL basic_busy: busy profile wrong (got %b expected 1)", bok);
    else n_pass++;
    n_checks++;
    if ({b.result, b.ovf} !== {16'd5, 1'b0})
      $display("FAIL basic_value: result=%0d ovf=%b expected 5 0", b.result, b.ovf);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({b.done, b.result} !== {1'b0, 16'd5})
      $display("FAIL done_single_cycle: done=%b result=%0d expected 0 5", b.done, b.result);
    else n_pass++;
  endtask

  task automatic test_general();
    int lat; bit bok;
    do_eval(pack3(2, 3, 4), 16'd10, 1'b0, lat, bok);
    n_checks++;
    if ({lat == DEG + 1, b.result, b.ovf} !== {1'b1, 16'd234, 1'b0})
      $display("FAIL general: lat=%0d result=%0d ovf=%b expected 3 234 0", lat, b.result, b.ovf);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int lat; bit bok;
    do_eval(pack3(1, 0, 0), 16'd300, 1'b0, lat, bok);
    n_checks++;
    if ({lat == DEG + 1, b.result, b.ovf} !== {1'b1, 16'd24464, 1'b1})
      $display("FAIL overflow: lat=%0d result=%0d ovf=%b expected 3 24464 1", lat, b.result, b.ovf);
    else n_pass++;
    do_eval(pack3(1, 0, 0), 16'd2, 1'b0, lat, bok);
    n_checks++;
    if ({lat == DEG + 1, b.result, b.ovf} !== {1'b1, 16'd4, 1'b0})
      $display("FAIL overflow_clears: lat=%0d result=%0d ovf=%b expected 3 4 0", lat, b.result, b.ovf);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int seen[$];
    logic [W-1:0] er; bit eo;
    int bad_val;
    bad_val = 0;
    b.coef  = pack3(2, 3, 4);
    b.x     = 16'd7;
    model(b.coef, b.x, er, eo);
    b.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (b.done) begin
        seen.push_back(k);
        if ({b.result, b.ovf} !== {er, eo}) bad_val++;
      end
    end
    b.start = 1'b0;
    n_checks++;
    if (seen.size() != 3 || seen[0] != 3 || seen[1] != 7 || seen[2] != 11)
      $display("FAIL back_to_back_timing: got %0d pulses first=%0d expected pulses at 3,7,11",
               seen.size(), (seen.size() > 0) ? seen[0] : -1);
    else n_pass++;
    n_checks++;
    if (bad_val != 0) $display("FAIL back_to_back_value: %0d wrong results expected 0", bad_val);
    else n_pass++;
    // drain the evaluation accepted at cycle 12
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_ignored_start();
    int dones;
    logic [W-1:0] er; bit eo;
    dones   = 0;
    b.coef  = pack3(5, 1, 9);
    b.x     = 16'd3;
    model(b.coef, b.x, er, eo);
    b.start = 1'b1;
    @(posedge clk); #1;   // E
    b.start = 1'b0;
    @(posedge clk); #1;   // E+1
    b.start = 1'b1;
    @(posedge clk); #1;   // E+2: extra request sampled while busy
    b.start = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      @(posedge clk); #1;
      if (b.done) dones++;
    end
    n_checks++;
    if (dones != 1 || b.result !== er || b.ovf !== eo)
      $display("FAIL ignored_start: dones=%0d result=%0d ovf=%b expected 1 %0d %b",
               dones, b.result, b.ovf, er, eo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, dones; bit bok;
    dones   = 0;
    b.coef  = pack3(9, 9, 9);
    b.x     = 16'd9;
    b.start = 1'b1;
    @(posedge clk); #1;   // E
    b.start = 1'b0;
    @(posedge clk); #3;   // E+1 plus 3
    rst = 1'b0;
    #1;
    n_checks++;
    if ({b.busy, b.done, b.ovf, b.result} !== {3'b000, 16'h0})
      $display("FAIL reset_mid: busy=%b done=%b ovf=%b result=%0d expected all 0",
               b.busy, b.done, b.ovf, b.result);
    else n_pass++;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (b.done) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL reset_mid_no_done: got %0d pulses expected 0", dones);
    else n_pass++;
    do_eval(pack3(3, 2, 0), 16'd1, 1'b0, lat, bok);
    n_checks++;
    if ({lat == DEG + 1, bok, b.result, b.ovf} !== {2'b11, 16'd5, 1'b0})
      $display("FAIL reset_recover: lat=%0d busy_ok=%b result=%0d ovf=%b expected 3 1 5 0",
               lat, bok, b.result, b.ovf);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [3*W-1:0] c;
    logic [W-1:0] xv, er;
    bit eo;
    for (int n = 0; n < 24; n++) begin
      c  = {W'($urandom()), 32'($urandom())};
      xv = (n % 3 == 0) ? W'($urandom_range(0, 4)) : W'($urandom());
      if (n % 4 == 1) c = c & {3{16'h00ff}};
      model(c, xv, er, eo);
      do_eval(c, xv, 1'b1, lat, bok);
      n_checks++;
      if ({lat == DEG + 1, bok, b.result, b.ovf} !== {2'b11, er, eo})
        $display("FAIL random_%0d: lat=%0d busy_ok=%b result=%0d ovf=%b expected 3 1 %0d %b",
                 n, lat, bok, b.result, b.ovf, er, eo);
      else n_pass++;
    end
  endtask

  task automatic test_deg0();
    int lat;
    logic [7:0] cv;
    for (int n = 0; n < 4; n++) begin
      cv = (n == 0) ? 8'd200 : 8'($urandom());
      b0.coef  = cv;
      b0.x     = (n == 0) ? 8'd7 : 8'($urandom());
      b0.start = 1'b1;
      @(posedge clk); #1;
      b0.start = 1'b0;
      b0.x     = 8'($urandom());
      b0.coef  = 8'($urandom());
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (b0.done) begin lat = k; break; end
      end
      n_checks++;
      if ({lat == 1, b0.result, b0.ovf, b0.busy} !== {1'b1, cv, 2'b00})
        $display("FAIL deg0_%0d: lat=%0d result=%0d ovf=%b busy=%b expected 1 %0d 0 0",
                 n, lat, b0.result, b0.ovf, b0.busy, cv);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_general();
    test_overflow();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_deg0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
